pill_line_plant: RTL

// - Plant-side model of the bottling line that drives the controller's sensor inputs.
// - Emits hopper pill pulses at a fixed rate and tracks the stock left in the hopper.
// - Moves the conveyor on request and reports whether a bottle is in place and whether the conveyor is healthy.
// - Sits on the board between the sim switches and the bottling controller, replacing the raw clk_1hz/switch hookup.

---
 rtl/pill_line_pkg.sv | 28 ++
 rtl/plant_pill_gen.sv | 56 +++++
 rtl/pill_line_plant.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pill_line_pkg.sv
// Shared definitions for the bottling-line plant model: conveyor state
// encodings and the parameter legality check used at elaboration.
package pill_line_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    JAMMED = 2'd2
  } conv_state_t;

  // True when the parameter set describes a buildable plant.
  function automatic bit plant_params_ok(
    input int unsigned pill_period,
    input int unsigned pill_high,
    input int unsigned switch_cycles,
    input int unsigned hopper_cap,
    input int unsigned stock_w
  );
    bit ok;
    ok = 1'b1;
    if (pill_high < 1 || pill_high >= pill_period) ok = 1'b0;
    if (switch_cycles < 1) ok = 1'b0;
    if (stock_w < 1 || stock_w > 30) ok = 1'b0;
    else if (hopper_cap >= (32'd1 << stock_w)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/plant_pill_gen.sv
// Hopper pill pulse generator: fixed-rate pulses of fixed width while the
// plant is eligible to dispense, plus a one-cycle strobe when a pulse starts.
module plant_pill_gen
  import pill_line_pkg::*;
#(
  parameter int PILL_PERIOD = 1000,
  parameter int PILL_HIGH   = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic eligible,
  input  logic halt,
  output logic pill_out,
  output logic pill_start
);

  localparam int PHASE_W = (PILL_PERIOD > 2) ? $clog2(PILL_PERIOD) : 1;
  localparam int WIDTH_W = $clog2(PILL_HIGH + 1);
  localparam logic [PHASE_W-1:0] PHASE_RELOAD = PHASE_W'(PILL_PERIOD - 1);
  localparam logic [WIDTH_W-1:0] WIDTH_RELOAD = WIDTH_W'(PILL_HIGH - 1);

  logic [PHASE_W-1:0] phase;
  logic [WIDTH_W-1:0] width;

  // A pulse still in flight (e.g. after eligibility blipped) blocks a restart.
  assign pill_start = eligible && (phase == '0) && !pill_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase    <= '0;
      width    <= '0;
      pill_out <= 1'b0;
    end else begin
      if (!eligible)
        phase <= '0;
      else if (pill_start)
        phase <= PHASE_RELOAD;
      else if (phase != '0)
        phase <= phase - PHASE_W'(1);

      // Only halt (emergency stop) may cut a running pulse short.
      if (pill_start) begin
        pill_out <= 1'b1;
        width    <= WIDTH_RELOAD;
      end else if (pill_out) begin
        if (halt || width == '0) begin
          pill_out <= 1'b0;
          width    <= '0;
        end else begin
          width <= width - WIDTH_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pill_line_plant.sv
// Plant-side model of the bottling line: pill hopper with stock tracking and
// refill, and a conveyor that can move, jam and report bottle position.
module pill_line_plant
  import pill_line_pkg::*;
#(
  parameter int PILL_PERIOD   = 1000,
  parameter int PILL_HIGH     = 500,
  parameter int SWITCH_CYCLES = 1500,
  parameter int HOPPER_CAP    = 999,
  parameter int REFILL_QTY    = 100,
  parameter int STOCK_W       = 10
) (
  input  logic               clk_1khz,
  input  logic               switch_clr,
  input  logic               fill_en,
  input  logic               switch_req,
  input  logic               emergncy_stop,
  input  logic               simu_hopper_stop,
  input  logic               simu_hopper_add,
  input  logic               simu_conveyor_stop,
  output logic               pill_out,
  output logic               bottle_in_place,
  output logic               conveyor_signal,
  output logic               hopper_empty,
  output logic [STOCK_W-1:0] stock,
  output logic [6:0]         bottles_moved
);

  if (!plant_params_ok(PILL_PERIOD, PILL_HIGH, SWITCH_CYCLES, HOPPER_CAP, STOCK_W)) begin : g_bad_params
    $error("pill_line_plant: illegal parameter set");
  end

  localparam int TRAVEL_W = $clog2(SWITCH_CYCLES + 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_RELOAD = TRAVEL_W'(SWITCH_CYCLES - 1);
  localparam logic [31:0] CAP32    = 32'(HOPPER_CAP);
  localparam logic [31:0] REFILL32 = 32'(REFILL_QTY);

  conv_state_t         state, state_next;
  logic [TRAVEL_W-1:0] travel, travel_next;
  logic [6:0]          moved_next;
  logic [STOCK_W-1:0]  stock_next;
  logic [31:0]         stock_sum;
  logic                add_q;
  logic                refill_rise;
  logic                eligible;
  logic                pill_start;

  assign bottle_in_place = (state == IDLE);
  assign conveyor_signal = ~simu_conveyor_stop;
  assign hopper_empty    = (stock == '0);
  assign refill_rise     = simu_hopper_add & ~add_q;
  assign eligible        = fill_en & bottle_in_place & ~hopper_empty
                         & ~simu_hopper_stop & ~emergncy_stop;

  plant_pill_gen #(
    .PILL_PERIOD (PILL_PERIOD),
    .PILL_HIGH   (PILL_HIGH)
  ) u_pill_gen (
    .clk        (clk_1khz),
    .rst_n      (switch_clr),
    .eligible   (eligible),
    .halt       (emergncy_stop),
    .pill_out   (pill_out),
    .pill_start (pill_start)
  );

  // Wide intermediate so a refill on top of a pill start saturates cleanly.
  always_comb begin
    stock_sum = 32'(stock) - 32'(pill_start);
    if (refill_rise) stock_sum = stock_sum + REFILL32;
    if (stock_sum > CAP32) stock_sum = CAP32;
    stock_next = STOCK_W'(stock_sum);
  end

  always_comb begin
    state_next  = state;
    travel_next = travel;
    moved_next  = bottles_moved;
    if (!emergncy_stop) begin
      case (state)
        IDLE: begin
          if (switch_req) begin
            state_next  = MOVING;
            travel_next = TRAVEL_RELOAD;
          end
        end
        MOVING: begin
          if (simu_conveyor_stop) begin
            state_next = JAMMED;
          end else if (travel == '0) begin
            state_next = IDLE;
            moved_next = bottles_moved + 7'd1;
          end else begin
            travel_next = travel - TRAVEL_W'(1);
          end
        end
        JAMMED: begin
          // The release cycle is itself a travel cycle.
          if (!simu_conveyor_stop) begin
            if (travel == '0) begin
              state_next = IDLE;
              moved_next = bottles_moved + 7'd1;
            end else begin
              state_next  = MOVING;
              travel_next = travel - TRAVEL_W'(1);
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (!switch_clr) begin
      state         <= IDLE;
      travel        <= '0;
      bottles_moved <= '0;
      stock         <= STOCK_W'(HOPPER_CAP);
      add_q         <= 1'b0;
    end else begin
      state         <= state_next;
      travel        <= travel_next;
      bottles_moved <= moved_next;
      stock         <= stock_next;
      add_q         <= simu_hopper_add;
    end
  end

endmodule
